// File: rtl/divider_recombine_seq.sv
// divider_recombine_seq
// Rebuilds the 2*DW-bit dividend from an array divider's quotient, divisor and
// remainder as n_out = q*d + r. A shift-add loop handles one quotient bit per
// cycle, LSB first, so latency is always DW cycles. It never exits early.
//
// Optional feature macro: RECOMB_ERR_EN
//   When defined, the original dividend n_ref is captured at acceptance.
//   On the edge that enters DONE, |n_ref - n_out| and a mismatch flag are
//   registered alongside n_out. When undefined, those ports and their logic
//   are absent.
module divider_recombine_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   q,
    input  logic [DW-1:0]   d,
    input  logic [DW-1:0]   r,
`ifdef RECOMB_ERR_EN
    input  logic [2*DW-1:0] n_ref,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] n_out
`ifdef RECOMB_ERR_EN
    ,
    output logic [2*DW-1:0] err_abs,
    output logic            err_flag
`endif
);

    // The step counter must be able to hold DW-1, which is the last RUN step.
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [2*DW-1:0] md_q, md_d;
    logic [DW-1:0]   mq_q, mq_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [2*DW-1:0] n_out_q, n_out_d;

    // The accumulator value after the current RUN step. It also feeds the
    // result registers on the final step.
    logic [2*DW-1:0] acc_step;
    logic            last_step;

`ifdef RECOMB_ERR_EN
    logic [2*DW-1:0] nref_q, nref_d;
    logic [2*DW-1:0] err_abs_q, err_abs_d;
    logic            err_flag_q, err_flag_d;
    logic [2*DW-1:0] err_abs_step;
    logic            err_flag_step;
`endif

    // Conditional add of the shifted divisor for the current quotient bit.
    // The maximum result is 2^(2DW) - 2^DW, so no carry-out needs to be kept.
    always_comb begin
        acc_step  = mq_q[0] ? (acc_q + md_q) : acc_q;
        last_step = (cnt_q == CW'(DW - 1));
    end

`ifdef RECOMB_ERR_EN
    // Absolute error against the captured dividend, evaluated on the final
    // accumulator value.
    always_comb begin
        if (nref_q >= acc_step) begin
            err_abs_step = nref_q - acc_step;
        end else begin
            err_abs_step = acc_step - nref_q;
        end
        err_flag_step = (nref_q != acc_step);
    end
`endif

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        md_d        = md_q;
        mq_d        = mq_q;
        cnt_d       = cnt_q;
        n_out_d     = n_out_q;
`ifdef RECOMB_ERR_EN
        nref_d      = nref_q;
        err_abs_d   = err_abs_q;
        err_flag_d  = err_flag_q;
`endif

        case (state_q)
            IDLE: begin
                // Operands are sampled only here. Later changes to q/d/r
                // (and n_ref) are deliberately ignored.
                if (in_valid) begin
                    acc_d   = {{DW{1'b0}}, r};
                    md_d    = {{DW{1'b0}}, d};
                    mq_d    = q;
                    cnt_d   = '0;
`ifdef RECOMB_ERR_EN
                    nref_d  = n_ref;
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                acc_d = acc_step;
                md_d  = md_q << 1;
                mq_d  = mq_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d    = DONE;
                    n_out_d    = acc_step;
`ifdef RECOMB_ERR_EN
                    err_abs_d  = err_abs_step;
                    err_flag_d = err_flag_step;
`endif
                end
            end

            DONE: begin
                // Results hold until downstream takes them. Input acceptance
                // waits for the following cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered and follow the next state, so
        // they are glitch-free and line up with the state register.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and registered outputs. An asynchronous reset aborts
    // any operation in flight and discards its result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            md_q        <= '0;
            mq_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            n_out_q     <= '0;
`ifdef RECOMB_ERR_EN
            nref_q      <= '0;
            err_abs_q   <= '0;
            err_flag_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            md_q        <= md_d;
            mq_q        <= mq_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            n_out_q     <= n_out_d;
`ifdef RECOMB_ERR_EN
            nref_q      <= nref_d;
            err_abs_q   <= err_abs_d;
            err_flag_q  <= err_flag_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign n_out     = n_out_q;
`ifdef RECOMB_ERR_EN
    assign err_abs   = err_abs_q;
    assign err_flag  = err_flag_q;
`endif

endmodule

// File: doc/divider_recombine_seq.md
# divider_recombine_seq

Sequential shift-add recombiner that rebuilds a 2·DW-bit dividend from an (approximate) array divider's quotient, divisor and remainder: n_out = q·d + r. It sits downstream of the divider array cells in the error-characterisation datapath. It turns each divider result back into the dividend domain so the approximate divider's error (MSE / power trade-off) can be measured against the original dividend in hardware.

## Interface
Parameters:
- DW, 8, operand width of q, d, r; n_out and n_ref are 2·DW bits.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set; equals (state==IDLE).
- q  input  DW  quotient from divider.
- d  input  DW  divisor.
- r  input  DW  remainder from divider.
- n_ref  input  2·DW  original dividend; present only with RECOMB_ERR_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- n_out  output  2·DW  recombined dividend q·d + r.
- err_abs  output  2·DW  |n_ref − n_out|; present only with RECOMB_ERR_EN.
- err_flag  output  1  n_out ≠ n_ref; present only with RECOMB_ERR_EN.

## Operation
- The block is an FSM with three states: IDLE, RUN and DONE. Reset forces IDLE.
- **IDLE:** in_ready=1. On in_valid && in_ready:
  - acc ← zero-extended r; md ← zero-extended d; mq ← q; cnt ← 0.
  - With RECOMB_ERR_EN, n_ref is latched.
  - Next state is RUN.
- **RUN:** in_ready=0. One multiplier bit is processed per cycle, LSB first:
  - if mq[0], acc ← acc + md (2·DW-bit add);
  - then md ← md<<1, mq ← mq>>1, cnt ← cnt+1.
  - After the DW-th RUN cycle, next state is DONE.
  - Latency is fixed: there is no early exit on mq==0.
- **DONE:** out_valid=1, n_out=acc, and outputs are held stable.
  - On out_valid && out_ready, next state is IDLE.
- **Width rule:** the maximum result (2^DW−1)² + (2^DW−1) = 2^2DW − 2^DW fits in 2·DW bits. No overflow is possible, so no carry-out is kept.
- **Special operands:** d=0 or q=0 gives n_out=r exactly. No divide-by-zero special case exists here.
- **Input timing:** inputs are sampled only on the acceptance edge. Changes on q/d/r/n_ref at any other time have no effect.
- **Reset mid-operation:** any rst assertion aborts the operation. The state returns to IDLE and the result is discarded; no out_valid pulse is produced.

## Timing
- **Reset values:**
  - out_valid=0, n_out=0, err_abs=0, err_flag=0.
  - in_ready=1, since the state is IDLE.
  - Internal acc, md, mq, cnt and the n_ref latch are all 0.
- **Acceptance:** occurs at clock edge E0 (in_valid && in_ready). Edges E1..EDW perform the DW add/shift steps.
- **Result:** out_valid is high from edge EDW onward, giving a latency of DW cycles from acceptance.
- **Back-pressure:** out_valid stays high and n_out/err_* stay constant while out_ready=0, for an unbounded time.
- **Release:** the result is released at the edge where out_valid && out_ready. in_ready rises in the following cycle.
- **Throughput:** at most one operand set per DW+2 cycles. There is no same-cycle output-release/input-accept overlap.
- **Register outputs:** n_out, err_abs and err_flag are registered, updated on the edge entering DONE. They do not glitch during RUN.

## Configuration
- **RECOMB_ERR_EN defined:**
  - The n_ref, err_abs and err_flag ports exist, and n_ref is latched at acceptance.
  - On the edge entering DONE, err_abs ← |n_ref − acc_final| and err_flag ← (acc_final ≠ n_ref).
  - Latency is unchanged.
- **RECOMB_ERR_EN undefined:**
  - The n_ref, err_abs and err_flag ports and their logic are absent.
  - The block is a pure recombiner.

## Test plan
- **Basic recombine:** q=0x05, d=0x03, r=0x01, out_ready=1.
  - out_valid rises 8 cycles after acceptance with n_out=0x0010.
  - in_ready returns high 1 cycle after release.
- **Maximum operands:** q=d=r=0xFF → n_out=0xFF00, with no truncation.
- **Zero operands:** d=0x00, q=0xA7, r=0x3C → n_out=0x003C. Separately, q=0x00, d=0x55, r=0x12 → n_out=0x0012. Both complete with the same 8-cycle latency.
- **Back-pressure:** out_ready held 0 for 20 cycles after out_valid.
  - n_out is stable and in_ready stays 0; in_valid pulses during this window are ignored.
  - Releasing out_ready completes the handshake, and the next operand is accepted afterwards.
- **Reset mid-run:** assert rst 4 cycles after acceptance.
  - All outputs go to 0 immediately and in_ready goes to 1.
  - No out_valid appears.
  - The next operation (q=0x02, d=0x02, r=0x00) yields n_out=0x0004.
- **RECOMB_ERR_EN on:**
  - q=0x05, d=0x03, r=0x01, n_ref=0x0011 → n_out=0x0010, err_abs=0x0001, err_flag=1.
  - The same operands with n_ref=0x0010 → err_abs=0, err_flag=0.
